// File: rtl/acq_sequencer.sv
// Sequences the sigma-delta ADC through reset/zero/cal, blanks the CIC start-up, then gates frame triggers.
// Optional: define ACQ_SEQ_AUTO_RECAL_EN to recalibrate automatically every RECAL_FRAMES triggers.
module acq_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int ZERO_CYCLES   = 4096,
  parameter int CAL_CYCLES    = 4096,
  parameter int DVAL_TIMEOUT  = 65535,
  parameter int SETTLE_FRAMES = 3,
  parameter int RECAL_FRAMES  = 1024,
  parameter int CNT_WIDTH     = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_cal_req,
  input  logic       i_dval,
  input  logic       i_dclk,
  output logic       o_adc_rst,
  output logic       o_adc_zero,
  output logic       o_adc_cal,
  output logic       o_stream_en,
  output logic       o_packet_trigger,
  output logic       o_fault,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    ST_ADC_RST   = 3'd0,
    ST_ZERO      = 3'd1,
    ST_CAL       = 3'd2,
    ST_WAIT_DVAL = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  localparam int CNT_LIMIT = 1 << CNT_WIDTH;
  // A mis-sized instance stays parked in ADC_RST rather than running with truncated timers.
  localparam bit CFG_OK = (RST_CYCLES > 0) && (RST_CYCLES < CNT_LIMIT) &&
                          (ZERO_CYCLES > 0) && (ZERO_CYCLES < CNT_LIMIT) &&
                          (CAL_CYCLES > 0) && (CAL_CYCLES < CNT_LIMIT) &&
                          (DVAL_TIMEOUT > 0) && (DVAL_TIMEOUT < CNT_LIMIT) &&
                          (SETTLE_FRAMES > 0) && (SETTLE_FRAMES < CNT_LIMIT) &&
                          (RECAL_FRAMES > 0) && (RECAL_FRAMES < CNT_LIMIT);

  localparam logic [CNT_WIDTH-1:0] RST_LAST    = CNT_WIDTH'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ZERO_LAST   = CNT_WIDTH'(ZERO_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CAL_LAST    = CNT_WIDTH'(CAL_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DVAL_LAST   = CNT_WIDTH'(DVAL_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SETTLE_FRAMES - 1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] timer_q, timer_d;
  logic                 dclk_q;
  logic                 trig_d;
  logic                 en;
  logic                 dclk_rise;
  logic                 recal_hit;

  assign en        = i_en & CFG_OK;
  assign dclk_rise = i_dclk & ~dclk_q;

`ifdef ACQ_SEQ_AUTO_RECAL_EN
  localparam logic [CNT_WIDTH-1:0] RECAL_LAST = CNT_WIDTH'(RECAL_FRAMES);
  logic [CNT_WIDTH-1:0] frame_q, frame_d;
  // Counter reaches RECAL_FRAMES while the last trigger is on the output, so leave on the next edge.
  assign recal_hit = (frame_q == RECAL_LAST);
`else
  assign recal_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    trig_d  = 1'b0;
`ifdef ACQ_SEQ_AUTO_RECAL_EN
    frame_d = frame_q;
`endif
    if (en || (state_q > ST_FAULT)) begin
      case (state_q)
        ST_ADC_RST: begin
          if (timer_q == RST_LAST) begin
            state_d = ST_ZERO;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_ZERO: begin
          if (timer_q == ZERO_LAST) begin
            state_d = ST_CAL;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_CAL: begin
          if (timer_q == CAL_LAST) begin
            state_d = ST_WAIT_DVAL;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_WAIT_DVAL: begin
          if (i_dval) begin
            state_d = ST_SETTLE;
            timer_d = '0;
          end else if (timer_q == DVAL_LAST) begin
            state_d = ST_FAULT;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_SETTLE: begin
          // Timer counts discarded decimator frames here, not cycles.
          if (dclk_rise) begin
            if (timer_q == SETTLE_LAST) begin
              state_d = ST_RUN;
              timer_d = '0;
`ifdef ACQ_SEQ_AUTO_RECAL_EN
              frame_d = '0;
`endif
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (i_cal_req || recal_hit) begin
            state_d = ST_ADC_RST;
            timer_d = '0;
          end else if (dclk_rise) begin
            trig_d = 1'b1;
`ifdef ACQ_SEQ_AUTO_RECAL_EN
            frame_d = frame_q + 1'b1;
`endif
          end
        end
        ST_FAULT: begin
          if (i_cal_req) begin
            state_d = ST_ADC_RST;
            timer_d = '0;
          end
        end
        default: begin
          state_d = ST_ADC_RST;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q          <= ST_ADC_RST;
      timer_q          <= '0;
      dclk_q           <= 1'b0;
      o_adc_rst        <= 1'b1;
      o_adc_zero       <= 1'b0;
      o_adc_cal        <= 1'b0;
      o_stream_en      <= 1'b0;
      o_packet_trigger <= 1'b0;
      o_fault          <= 1'b0;
`ifdef ACQ_SEQ_AUTO_RECAL_EN
      frame_q          <= '0;
`endif
    end else begin
      state_q          <= state_d;
      timer_q          <= timer_d;
      dclk_q           <= i_dclk;
      o_adc_rst        <= (state_d == ST_ADC_RST);
      o_adc_zero       <= (state_d == ST_ZERO);
      o_adc_cal        <= (state_d == ST_CAL);
      o_stream_en      <= (state_d == ST_RUN);
      o_packet_trigger <= trig_d;
      o_fault          <= (state_d == ST_FAULT);
`ifdef ACQ_SEQ_AUTO_RECAL_EN
      frame_q          <= frame_d;
`endif
    end
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Table-driven bench for acq_sequencer: per-cycle expectations queued at drive time, compared after the edge.
module tb_acq_sequencer;

  localparam logic [2:0] S_RST = 3'd0, S_ZERO = 3'd1, S_CAL = 3'd2, S_WAIT = 3'd3,
                         S_SETTLE = 3'd4, S_RUN = 3'd5, S_FAULT = 3'd6;

  typedef struct {
    string      name;
    int         n;
    logic       en;
    logic       cal;
    logic       dval;
    logic       dclk;
    logic [2:0] st;
    logic       trig;
  } vec_t;

  typedef struct {
    string      name;
    logic [8:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       cal_req = 1'b0;
  logic       dval = 1'b1;
  logic       dclk = 1'b0;
  logic       adc_rst, adc_zero, adc_cal, stream_en, trig, fault;
  logic [2:0] state;

  acq_sequencer #(
    .RST_CYCLES   (4),
    .ZERO_CYCLES  (8),
    .CAL_CYCLES   (8),
    .DVAL_TIMEOUT (32),
    .SETTLE_FRAMES(3),
    .RECAL_FRAMES (5),
    .CNT_WIDTH    (16)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_en            (en),
    .i_cal_req       (cal_req),
    .i_dval          (dval),
    .i_dclk          (dclk),
    .o_adc_rst       (adc_rst),
    .o_adc_zero      (adc_zero),
    .o_adc_cal       (adc_cal),
    .o_stream_en     (stream_en),
    .o_packet_trigger(trig),
    .o_fault         (fault),
    .o_state         (state)
  );

  always #5 clk = ~clk;

  // Expected output word derived from the state: one-hot strobes, stream/fault flags, trigger, state code.
  function automatic logic [8:0] exp_word(input logic [2:0] st, input logic tr);
    return {st == S_RST, st == S_ZERO, st == S_CAL, st == S_RUN, tr, st == S_FAULT, st};
  endfunction

  function automatic logic [8:0] act_word();
    return {adc_rst, adc_zero, adc_cal, stream_en, trig, fault, state};
  endfunction

  task automatic check(input string name, input logic [8:0] exp);
    logic [8:0] act;
    act = act_word();
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (rst zero cal str trig flt st[2:0])", name, act, exp);
    end else begin
      $display("ok   %s: %b", name, act);
    end
  endtask

  task automatic add(input string name, input int n, input logic e, input logic c,
                     input logic d, input logic k, input logic [2:0] st, input logic tr);
    vec_t v;
    v.name = name; v.n = n; v.en = e; v.cal = c; v.dval = d; v.dclk = k; v.st = st; v.trig = tr;
    vecs.push_back(v);
  endtask

  task automatic add_powerup(input string tag);
    add({tag, "_rst"},  3, 1'b1, 1'b0, 1'b1, 1'b0, S_RST,  1'b0);
    add({tag, "_zero"}, 8, 1'b1, 1'b0, 1'b1, 1'b0, S_ZERO, 1'b0);
    add({tag, "_cal"},  8, 1'b1, 1'b0, 1'b1, 1'b0, S_CAL,  1'b0);
    add({tag, "_wait"}, 1, 1'b1, 1'b0, 1'b1, 1'b0, S_WAIT, 1'b0);
  endtask

  // Three blanked dclk rises; the third one enters RUN without a trigger.
  task automatic add_settle(input string tag);
    add({tag, "_s_lo0"}, 8, 1'b1, 1'b0, 1'b1, 1'b0, S_SETTLE, 1'b0);
    add({tag, "_s_hi1"}, 8, 1'b1, 1'b0, 1'b1, 1'b1, S_SETTLE, 1'b0);
    add({tag, "_s_lo1"}, 8, 1'b1, 1'b0, 1'b1, 1'b0, S_SETTLE, 1'b0);
    add({tag, "_s_hi2"}, 8, 1'b1, 1'b0, 1'b1, 1'b1, S_SETTLE, 1'b0);
    add({tag, "_s_lo2"}, 8, 1'b1, 1'b0, 1'b1, 1'b0, S_SETTLE, 1'b0);
    add({tag, "_s_hi3"}, 1, 1'b1, 1'b0, 1'b1, 1'b1, S_RUN,    1'b0);
    add({tag, "_s_hi3b"}, 7, 1'b1, 1'b0, 1'b1, 1'b1, S_RUN,   1'b0);
  endtask

  task automatic add_frame(input string tag);
    add({tag, "_lo"},   8, 1'b1, 1'b0, 1'b1, 1'b0, S_RUN, 1'b0);
    add({tag, "_trig"}, 1, 1'b1, 1'b0, 1'b1, 1'b1, S_RUN, 1'b1);
    add({tag, "_hi"},   7, 1'b1, 1'b0, 1'b1, 1'b1, S_RUN, 1'b0);
  endtask

  task automatic run_vecs();
    sb_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        en      = vecs[i].en;
        cal_req = vecs[i].cal;
        dval    = vecs[i].dval;
        dclk    = vecs[i].dclk;
        e.name  = $sformatf("%s[%0d]", vecs[i].name, j);
        e.exp   = exp_word(vecs[i].st, vecs[i].trig);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(e.name, e.exp);
      end
    end
    vecs.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", exp_word(S_RST, 1'b0));
    #3 rst_n = 1'b1;

    // Power-up sequence, first trigger on the fourth dclk rise.
    add_powerup("pwr");
    add_settle("pwr");
    add_frame("pwr_f1");
    // Request coincident with a rise: no trigger, back to ADC_RST; request held through CAL is ignored.
    add("req_gap",       8, 1'b1, 1'b0, 1'b1, 1'b0, S_RUN,  1'b0);
    add("req_rise",      1, 1'b1, 1'b1, 1'b1, 1'b1, S_RST,  1'b0);
    add("req_held_rst",  3, 1'b1, 1'b1, 1'b1, 1'b1, S_RST,  1'b0);
    add("req_held_zero", 8, 1'b1, 1'b1, 1'b1, 1'b1, S_ZERO, 1'b0);
    add("req_held_cal",  8, 1'b1, 1'b1, 1'b1, 1'b1, S_CAL,  1'b0);
    // No data-valid: 32 cycles in WAIT_DVAL, then FAULT until a request.
    add("tmo_wait",  32, 1'b1, 1'b0, 1'b0, 1'b0, S_WAIT,  1'b0);
    add("tmo_fault",  4, 1'b1, 1'b0, 1'b0, 1'b0, S_FAULT, 1'b0);
    add("fault_req",  1, 1'b1, 1'b1, 1'b0, 1'b0, S_RST,   1'b0);
    // Enable dropped for 10 cycles mid-ZERO stretches the strobe to 18 cycles.
    add("en_rst",      3, 1'b1, 1'b0, 1'b1, 1'b0, S_RST,  1'b0);
    add("en_zero_a",   4, 1'b1, 1'b0, 1'b1, 1'b0, S_ZERO, 1'b0);
    add("en_zero_off",10, 1'b0, 1'b0, 1'b1, 1'b0, S_ZERO, 1'b0);
    add("en_zero_b",   4, 1'b1, 1'b0, 1'b1, 1'b0, S_ZERO, 1'b0);
    add("en_cal",      8, 1'b1, 1'b0, 1'b1, 1'b0, S_CAL,  1'b0);
    add("en_wait",     1, 1'b1, 1'b0, 1'b1, 1'b0, S_WAIT, 1'b0);
    add_settle("en");
    // Rise while disabled is lost; later frames trigger normally.
    add("en_gap",      8, 1'b1, 1'b0, 1'b1, 1'b0, S_RUN, 1'b0);
    add("en_off_rise", 8, 1'b0, 1'b0, 1'b1, 1'b1, S_RUN, 1'b0);
    add_frame("en_f1");
    add_frame("en_f2");
    // Walk back into CAL ahead of the asynchronous reset.
    add("pre_req",  1, 1'b1, 1'b1, 1'b1, 1'b0, S_RST,  1'b0);
    add("pre_rst",  3, 1'b1, 1'b0, 1'b1, 1'b0, S_RST,  1'b0);
    add("pre_zero", 8, 1'b1, 1'b0, 1'b1, 1'b0, S_ZERO, 1'b0);
    add("pre_cal",  3, 1'b1, 1'b0, 1'b1, 1'b0, S_CAL,  1'b0);
    run_vecs();

    // Asynchronous reset between clock edges takes effect without a clock.
    #2 rst_n = 1'b0;
    #1 check("async_rst_midcal", exp_word(S_RST, 1'b0));
    #1 rst_n = 1'b1;

    add_powerup("ar");
    add_settle("ar");
`ifdef ACQ_SEQ_AUTO_RECAL_EN
    for (int f = 1; f <= 4; f++) add_frame($sformatf("ar_f%0d", f));
    add("ar_f5_lo",   8, 1'b1, 1'b0, 1'b1, 1'b0, S_RUN,  1'b0);
    add("ar_f5_trig", 1, 1'b1, 1'b0, 1'b1, 1'b1, S_RUN,  1'b1);
    add("ar_recal",   4, 1'b1, 1'b0, 1'b1, 1'b1, S_RST,  1'b0);
    add("ar_zero",    3, 1'b1, 1'b0, 1'b1, 1'b1, S_ZERO, 1'b0);
`else
    for (int f = 1; f <= 7; f++) add_frame($sformatf("ar_f%0d", f));
`endif
    run_vecs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
